// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit. Builds one 32-bit little-endian instruction from
// four byte reads on the shared byte-wide memory port. It then presents the
// instruction and its PC to decode, and redirects on a branch/jump from
// execute.
//
// Ports
//   clk_in            rising-edge clock
//   rst_in            asynchronous, active-low reset
//   stall_in          decode cannot take the held instruction this cycle
//   branch_flag_in    one-cycle redirect request from execute
//   branch_target_in  redirect PC, used as-is
//   mem_req_out       byte read request
//   mem_addr_out      byte address of the request, 0 when no request
//   mem_gnt_in        request accepted this cycle
//   mem_data_in       read data, valid the cycle after a granted request
//   inst_valid_out    inst_out/pc_out hold a complete instruction
//   pc_out            address of inst_out
//   inst_out          assembled instruction, byte k = mem[pc+k]
//   fsm_state_out     current FSM state (debug visibility)
//
// Handshakes
//   Memory side: a request is taken on any cycle where mem_req_out and
//   mem_gnt_in are both 1. Its byte appears on mem_data_in in the next cycle.
//   A refused request is held unchanged until it is granted.
//   Decode side: when inst_valid_out is 1, the instruction is consumed on
//   every cycle where stall_in is 0. inst_out/pc_out are held stable until it
//   is consumed. A redirect squashes the instruction, even when it is
//   consumed in the same cycle.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_gnt_in,
  input  logic [7:0]  mem_data_in,
  output logic        inst_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic [1:0]  fsm_state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        pend;
  logic [1:0]  pend_idx;
  logic [31:0] asm_buf;
  logic [31:0] asm_word;
  logic        last_byte;

  assign fsm_state_out = state;

  // The request depends only on registered state, so the arbiter's grant
  // never feeds back into the request it is answering.
  assign mem_req_out  = (state == FETCH) && (issue_cnt < 3'd4);
  assign mem_addr_out = mem_req_out ? (fetch_pc + {29'd0, issue_cnt}) : 32'd0;

  // The fourth byte is arriving this cycle. It completes the word at the edge.
  assign last_byte = (state == FETCH) && pend && (recv_cnt == 3'd3);

  // Assembly buffer with the arriving byte merged in. This value is used both
  // for the buffer update and for the completed-word load.
  always_comb begin
    asm_word = asm_buf;
    case (pend_idx)
      2'd0:    asm_word[7:0]   = mem_data_in;
      2'd1:    asm_word[15:8]  = mem_data_in;
      2'd2:    asm_word[23:16] = mem_data_in;
      default: asm_word[31:24] = mem_data_in;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (branch_flag_in) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (last_byte) state_nxt = DONE;
        DONE:    if (!stall_in) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc       <= RESET_PC;
      issue_cnt      <= 3'd0;
      recv_cnt       <= 3'd0;
      pend           <= 1'b0;
      pend_idx       <= 2'd0;
      asm_buf        <= 32'd0;
      inst_out       <= 32'd0;
      pc_out         <= RESET_PC;
      inst_valid_out <= 1'b0;
    end else if (branch_flag_in) begin
      // Clearing pend drops the byte of any request still in flight.
      fetch_pc       <= branch_target_in;
      issue_cnt      <= 3'd0;
      recv_cnt       <= 3'd0;
      pend           <= 1'b0;
      inst_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fetch_pc  <= RESET_PC;
          issue_cnt <= 3'd0;
          recv_cnt  <= 3'd0;
          pend      <= 1'b0;
        end
        FETCH: begin
          if (mem_req_out && mem_gnt_in) begin
            issue_cnt <= issue_cnt + 3'd1;
            pend      <= 1'b1;
            pend_idx  <= issue_cnt[1:0];
          end else begin
            pend <= 1'b0;
          end
          if (pend) begin
            asm_buf  <= asm_word;
            recv_cnt <= recv_cnt + 3'd1;
          end
          if (last_byte) begin
            inst_out       <= asm_word;
            pc_out         <= fetch_pc;
            inst_valid_out <= 1'b1;
          end
        end
        DONE: begin
          if (!stall_in) begin
            inst_valid_out <= 1'b0;
            fetch_pc       <= fetch_pc + 32'd4;
            issue_cnt      <= 3'd0;
            recv_cnt       <= 3'd0;
          end
        end
        default: begin
          pend <= 1'b0;
        end
      endcase
    end
  end

endmodule
